// File: rtl/rcd_parity_pkg.sv
// Shared definitions for the RCD parity alert path.
//   alert_state_e : alert FSM encoding (IDLE=0, ALERT=1, BLOCK=2; 3 is illegal)
//   DEF_*         : default widths used by the controller and its interface
//   sat_inc       : saturating increment for counters up to 32 bits wide
package rcd_parity_pkg;

  localparam int DEF_NUM_BUSES = 4;
  localparam int DEF_DWIDTH    = 64;
  localparam int DEF_PW_WIDTH  = 8;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    BLOCK = 2'd2
  } alert_state_e;

  // v is a w-bit counter zero-extended to 32 bits; holds at the w-bit all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/parity_alert_ctrl_if.sv
// Bus from the parity checker into the alert controller.
//   err_valid  : qualified error strobe
//   err_vector : per-bus parity error flags, bit i = bus i
//   bus_in     : the words the checker evaluated this cycle, parity in the MSB
// Modports: master = checker side (drives), slave = controller side (samples).
interface parity_alert_ctrl_if #(
  parameter int NUM_BUSES = 4,
  parameter int DWIDTH    = 64
);
  logic                             err_valid;
  logic [NUM_BUSES-1:0]             err_vector;
  logic [NUM_BUSES-1:0][DWIDTH:0]   bus_in;

  modport master (output err_valid, err_vector, bus_in);
  modport slave  (input  err_valid, err_vector, bus_in);
endinterface

// File: rtl/parity_alert_timer.sv
// ALERT_n pulse-width counter.
//   clk, rst  : clock, async active-high reset
//   load_i    : load the counter with max(width_i,1)
//   dec_i     : count down one step (held while the alert is active)
//   width_i   : configured pulse width; 0 is treated as 1
//   last_o    : counter equals 1, i.e. this is the final alert cycle
module parity_alert_timer #(
  parameter int PW_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [PW_WIDTH-1:0] width_i,
  output logic                last_o
);

  logic [PW_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = (width_i == '0) ? PW_WIDTH'(1) : width_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - PW_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == PW_WIDTH'(1));

endmodule

// File: rtl/parity_alert_ctrl.sv
// Parity alert controller: turns checker error strobes into a timed active-low
// ALERT_n pulse, blocks command forwarding until software clears it, logs the
// first failing bus/word and keeps a saturating error count.
//   clk, rst         : clock, async active-high reset
//   chk_if (slave)   : err_valid / err_vector / bus_in from the parity checker
//   cfg_pulse_width  : ALERT_n low time in cycles (0 behaves as 1)
//   cfg_block_en     : hold cmd_block after the pulse until clr
//   clr              : clear sticky log / block state
//   alert_n, cmd_block, err_sticky, err_log_*, err_count, err_overflow, state_o
// Build option: PARITY_ALERT_LOG_EN builds the log registers; without it the
// three err_log_* outputs are tied to zero.
module parity_alert_ctrl
  import rcd_parity_pkg::*;
#(
  parameter int NUM_BUSES = DEF_NUM_BUSES,
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int PW_WIDTH  = DEF_PW_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_alert_ctrl_if.slave    chk_if,
  input  logic [PW_WIDTH-1:0]   cfg_pulse_width,
  input  logic                  cfg_block_en,
  input  logic                  clr,
  output logic                  alert_n,
  output logic                  cmd_block,
  output logic                  err_sticky,
  output logic [7:0]            err_log_bus_id,
  output logic [NUM_BUSES-1:0]  err_log_vector,
  output logic [DWIDTH:0]       err_log_word,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_overflow,
  output logic [1:0]            state_o
);

  alert_state_e state_q, state_d;
  logic err_evt, tmr_last, capture, clear;
  logic alert_n_q, alert_n_d, cmd_block_q, cmd_block_d;
  logic sticky_q, sticky_d, ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // A strobe with an empty vector is not an event at all.
  assign err_evt = chk_if.err_valid && (|chk_if.err_vector);
  assign capture = (state_q == IDLE) && err_evt;
  // clr is honoured in IDLE and BLOCK only; in IDLE a coincident error re-sets
  // the sticky/log afterwards, in BLOCK the clear wins outright.
  assign clear   = clr && ((state_q == IDLE) || (state_q == BLOCK));

  parity_alert_timer #(.PW_WIDTH(PW_WIDTH)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (capture),
    .dec_i   (state_q == ALERT),
    .width_i (cfg_pulse_width),
    .last_o  (tmr_last)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (err_evt)  state_d = ALERT;
      ALERT:   if (tmr_last) state_d = cfg_block_en ? BLOCK : IDLE;
      BLOCK:   if (clr)      state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // FSM outputs: computed from the next state so the pins are registered yet
  // change in the same cycle the state does.
  always_comb begin
    alert_n_d   = (state_d != ALERT);
    cmd_block_d = (state_d == ALERT) || (state_d == BLOCK);
  end

  // Count, sticky and overflow
  always_comb begin
    cnt_d    = err_evt ? CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH)) : cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (clear) begin
      sticky_d = 1'b0;
      ovf_d    = 1'b0;
    end
    if (capture) sticky_d = 1'b1;
    if (err_evt && ((state_q == ALERT) || ((state_q == BLOCK) && !clr)))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alert_n_q   <= 1'b1;
      cmd_block_q <= 1'b0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      alert_n_q   <= alert_n_d;
      cmd_block_q <= cmd_block_d;
      sticky_q    <= sticky_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PARITY_ALERT_LOG_EN
  logic [7:0]           sel_id, log_id_q, log_id_d;
  logic [DWIDTH:0]      sel_word, log_word_q, log_word_d;
  logic [NUM_BUSES-1:0] log_vec_q, log_vec_d;

  // Lowest failing bus: scan high to low so the last hit is the lowest index.
  always_comb begin
    sel_id   = '0;
    sel_word = '0;
    for (int i = NUM_BUSES-1; i >= 0; i--) begin
      if (chk_if.err_vector[i]) begin
        sel_id   = 8'(i);
        sel_word = chk_if.bus_in[i];
      end
    end
  end

  always_comb begin
    log_id_d   = log_id_q;
    log_word_d = log_word_q;
    log_vec_d  = log_vec_q;
    if (clear) begin
      log_id_d   = '0;
      log_word_d = '0;
      log_vec_d  = '0;
    end
    if (capture) begin
      log_id_d   = sel_id;
      log_word_d = sel_word;
      log_vec_d  = chk_if.err_vector;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_id_q   <= '0;
      log_word_q <= '0;
      log_vec_q  <= '0;
    end else begin
      log_id_q   <= log_id_d;
      log_word_q <= log_word_d;
      log_vec_q  <= log_vec_d;
    end
  end

  assign err_log_bus_id = log_id_q;
  assign err_log_vector = log_vec_q;
  assign err_log_word   = log_word_q;
`else
  assign err_log_bus_id = '0;
  assign err_log_vector = '0;
  assign err_log_word   = '0;
`endif

  assign alert_n      = alert_n_q;
  assign cmd_block    = cmd_block_q;
  assign err_sticky   = sticky_q;
  assign err_count    = cnt_q;
  assign err_overflow = ovf_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_parity_alert_ctrl.sv
// Directed bench for parity_alert_ctrl. Log expectations collapse to zero when
// PARITY_ALERT_LOG_EN is not defined.
module tb_parity_alert_ctrl;
  import rcd_parity_pkg::*;

  localparam int NB = 4, DW = 64, PW = 8, CW = 16;
`ifdef PARITY_ALERT_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif
  localparam logic [DW:0] W0 = 65'h0_0000_0000_0000_1000;
  localparam logic [DW:0] W1 = 65'h1_1111_2222_3333_4444;
  localparam logic [DW:0] W2 = 65'h0_DEAD_BEEF_CAFE_0002;
  localparam logic [DW:0] W3 = 65'h1_8000_0000_0000_0003;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] cfg_pulse_width;
  logic cfg_block_en, clr;
  logic alert_n, cmd_block, err_sticky, err_overflow;
  logic [7:0] err_log_bus_id;
  logic [NB-1:0] err_log_vector;
  logic [DW:0] err_log_word;
  logic [CW-1:0] err_count;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;

  parity_alert_ctrl_if #(.NUM_BUSES(NB), .DWIDTH(DW)) pif ();

  parity_alert_ctrl #(.NUM_BUSES(NB), .DWIDTH(DW), .PW_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .chk_if(pif.slave),
    .cfg_pulse_width(cfg_pulse_width), .cfg_block_en(cfg_block_en), .clr(clr),
    .alert_n(alert_n), .cmd_block(cmd_block), .err_sticky(err_sticky),
    .err_log_bus_id(err_log_bus_id), .err_log_vector(err_log_vector),
    .err_log_word(err_log_word), .err_count(err_count),
    .err_overflow(err_overflow), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    pif.err_valid = 1'b0;
    pif.err_vector = '0;
    clr = 1'b0;
  endtask

  task automatic err_in(input logic [NB-1:0] v);
    pif.err_valid = 1'b1;
    pif.err_vector = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_in();
    pif.bus_in[0] = W0; pif.bus_in[1] = W1; pif.bus_in[2] = W2; pif.bus_in[3] = W3;
    cfg_pulse_width = 8'd4;
    cfg_block_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL reset_alert_n: got %b want 1", alert_n); end
    checks++; if (cmd_block !== 1'b0) begin errors++; $display("FAIL reset_cmd_block: got %b want 0", cmd_block); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b want 0", err_sticky); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0", err_count); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", err_overflow); end
    checks++; if (err_log_vector !== 4'd0) begin errors++; $display("FAIL reset_log_vec: got %b want 0", err_log_vector); end
    checks++; if (err_log_word !== 65'd0) begin errors++; $display("FAIL reset_log_word: got %h want 0", err_log_word); end
  endtask

  task automatic test_zero_vector();
    pif.err_valid = 1'b1;
    pif.err_vector = 4'b0000;
    tick(); tick();
    idle_in();
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL zerovec_count: got %h want %h", err_count, exp_cnt); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL zerovec_state: got %0d want 0", state_o); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL zerovec_sticky: got %b want 0", err_sticky); end
  endtask

  task automatic test_pulse_no_block();
    cfg_pulse_width = 8'd4;
    cfg_block_en = 1'b0;
    err_in(4'b0100);
    tick();
    idle_in();
    exp_cnt++;
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL pulse_count: got %h want %h", err_count, exp_cnt); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL pulse_sticky: got %b want 1", err_sticky); end
    checks++; if (err_log_bus_id !== (LOG_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL pulse_log_id: got %0d", err_log_bus_id); end
    checks++; if (err_log_word !== (LOG_EN ? W2 : 65'd0)) begin errors++; $display("FAIL pulse_log_word: got %h", err_log_word); end
    checks++; if (err_log_vector !== (LOG_EN ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL pulse_log_vec: got %b", err_log_vector); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL pulse_alert_low cyc%0d: got %b want 0", k, alert_n); end
      checks++; if (cmd_block !== 1'b1) begin errors++; $display("FAIL pulse_block cyc%0d: got %b want 1", k, cmd_block); end
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL pulse_state cyc%0d: got %0d want 1", k, state_o); end
      tick();
    end
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL pulse_end_alert_n: got %b want 1", alert_n); end
    checks++; if (cmd_block !== 1'b0) begin errors++; $display("FAIL pulse_end_block: got %b want 0", cmd_block); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL pulse_end_state: got %0d want 0", state_o); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL idle_clr_sticky: got %b want 0", err_sticky); end
    checks++; if (err_log_vector !== 4'd0) begin errors++; $display("FAIL idle_clr_log: got %b want 0", err_log_vector); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL idle_clr_count: got %h want %h", err_count, exp_cnt); end
  endtask

  task automatic test_block_clr();
    cfg_pulse_width = 8'd0;
    cfg_block_en = 1'b1;
    err_in(4'b1010);
    tick();
    idle_in();
    exp_cnt++;
    checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL blk_alert_low: got %b want 0", alert_n); end
    checks++; if (err_log_bus_id !== (LOG_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL blk_log_id: got %0d", err_log_bus_id); end
    checks++; if (err_log_word !== (LOG_EN ? W1 : 65'd0)) begin errors++; $display("FAIL blk_log_word: got %h", err_log_word); end
    tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL blk_alert_one_cycle: got %b want 1", alert_n); end
    checks++; if (cmd_block !== 1'b1) begin errors++; $display("FAIL blk_block: got %b want 1", cmd_block); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL blk_state: got %0d want 2", state_o); end
    tick(); tick(); tick();
    checks++; if (cmd_block !== 1'b1) begin errors++; $display("FAIL blk_hold: got %b want 1", cmd_block); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (cmd_block !== 1'b0) begin errors++; $display("FAIL blk_clr_block: got %b want 0", cmd_block); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL blk_clr_sticky: got %b want 0", err_sticky); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL blk_clr_state: got %0d want 0", state_o); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL blk_count: got %h want %h", err_count, exp_cnt); end
  endtask

  task automatic test_overflow();
    cfg_pulse_width = 8'd5;
    cfg_block_en = 1'b0;
    err_in(4'b0001);
    tick();
    exp_cnt++;
    for (int k = 0; k < 3; k++) begin
      err_in(4'b1000);
      tick();
      exp_cnt++;
      checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL ovf_alert_low cyc%0d: got %b want 0", k + 2, alert_n); end
    end
    idle_in();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL ovf_alert_cyc5: got %b want 0", alert_n); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ovf_clr_ignored: got %b want 1", err_sticky); end
    tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL ovf_pulse_len: got %b want 1", alert_n); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL ovf_count: got %h want %h", err_count, exp_cnt); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
    checks++; if (err_log_vector !== (LOG_EN ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL ovf_log_vec: got %b", err_log_vector); end
    checks++; if (err_log_word !== (LOG_EN ? W0 : 65'd0)) begin errors++; $display("FAIL ovf_log_word: got %h", err_log_word); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", err_overflow); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL ovf_clr_count: got %h want %h", err_count, exp_cnt); end
  endtask

  task automatic test_clr_err_block();
    cfg_pulse_width = 8'd1;
    cfg_block_en = 1'b1;
    err_in(4'b0010);
    tick();
    idle_in();
    exp_cnt++;
    tick();
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL ce_state_block: got %0d want 2", state_o); end
    clr = 1'b1;
    err_in(4'b0100);
    tick();
    idle_in();
    exp_cnt++;
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL ce_state: got %0d want 0", state_o); end
    checks++; if (cmd_block !== 1'b0) begin errors++; $display("FAIL ce_block: got %b want 0", cmd_block); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL ce_sticky: got %b want 0", err_sticky); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ce_ovf: got %b want 0", err_overflow); end
    checks++; if (err_log_vector !== 4'd0) begin errors++; $display("FAIL ce_log: got %b want 0", err_log_vector); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL ce_count: got %h want %h", err_count, exp_cnt); end
    tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL ce_no_pulse: got %b want 1", alert_n); end
  endtask

  task automatic test_idle_clr_err_back_to_back();
    cfg_pulse_width = 8'd2;
    cfg_block_en = 1'b0;
    err_in(4'b0001);
    tick();
    exp_cnt++;
    tick();
    exp_cnt++;
    idle_in();
    tick();
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ic_ovf_set: got %b want 1", err_overflow); end
    clr = 1'b1;
    err_in(4'b1000);
    tick();
    idle_in();
    exp_cnt++;
    checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL ic_state: got %0d want 1", state_o); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL ic_sticky: got %b want 1", err_sticky); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ic_ovf: got %b want 0", err_overflow); end
    checks++; if (err_log_bus_id !== (LOG_EN ? 8'd3 : 8'd0)) begin errors++; $display("FAIL ic_log_id: got %0d", err_log_bus_id); end
    checks++; if (err_log_word !== (LOG_EN ? W3 : 65'd0)) begin errors++; $display("FAIL ic_log_word: got %h", err_log_word); end
    tick(); tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL b2b_gap: got %b want 1", alert_n); end
    err_in(4'b0100);
    tick();
    idle_in();
    exp_cnt++;
    checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL b2b_alert: got %b want 0", alert_n); end
    checks++; if (err_log_bus_id !== (LOG_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL b2b_log_id: got %0d", err_log_bus_id); end
    tick(); tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL b2b_end: got %b want 1", alert_n); end
    checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL b2b_count: got %h want %h", err_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    cfg_pulse_width = 8'd1;
    cfg_block_en = 1'b1;
    err_in(4'b0001);
    while (exp_cnt != 16'hFFFE) begin
      tick();
      exp_cnt++;
    end
    checks++; if (err_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want fffe", err_count); end
    checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d want 2", state_o); end
    tick();
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want ffff", err_count); end
    tick();
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", err_count); end
    idle_in();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_count !== 16'hFFFF) begin errors++; $display("FAIL sat_clr_keep: got %h want ffff", err_count); end
  endtask

  task automatic test_reset_mid_alert();
    cfg_pulse_width = 8'd10;
    cfg_block_en = 1'b0;
    err_in(4'b0001);
    tick();
    idle_in();
    tick();
    checks++; if (alert_n !== 1'b0) begin errors++; $display("FAIL rma_pre: got %b want 0", alert_n); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL rma_alert_n: got %b want 1", alert_n); end
    checks++; if (cmd_block !== 1'b0) begin errors++; $display("FAIL rma_block: got %b want 0", cmd_block); end
    checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rma_state: got %0d want 0", state_o); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rma_count: got %h want 0", err_count); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rma_sticky: got %b want 0", err_sticky); end
    checks++; if (err_log_vector !== 4'd0) begin errors++; $display("FAIL rma_log: got %b want 0", err_log_vector); end
    #2;
    rst = 1'b0;
    tick();
    checks++; if (alert_n !== 1'b1) begin errors++; $display("FAIL rma_after: got %b want 1", alert_n); end
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_pulse_no_block();
    test_block_clr();
    test_overflow();
    test_clr_err_block();
    test_idle_clr_err_back_to_back();
    test_saturation();
    test_reset_mid_alert();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_alert_ctrl.md
# parity_alert_ctrl

Downstream consumer of the RCD bus parity checker. It takes the per-bus parity error vector and the checked bus words. On the first error it drives a timed active-low ALERT_n pulse and blocks command forwarding until software clears it. It also logs the first failing bus and word, and keeps a saturating error count plus an overflow flag. It sits between the parity checker and the command forwarding/alert pad logic.

## Interface
- NUM_BUSES, 4, number of checked buses; must equal the checker's bus count.
- DWIDTH, 64, data bits per bus; each word carries DWIDTH+1 bits, parity in the MSB.
- PW_WIDTH, 8, width of the ALERT_n pulse-width config field.
- CNT_WIDTH, 16, width of the error counter.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- err_valid  in  1  qualified error strobe from the checker (error present and reporting enabled).
- err_vector  in  NUM_BUSES  per-bus parity error flags, bit i = bus i.
- bus_in  in  NUM_BUSES x (DWIDTH+1)  the same words the checker evaluated this cycle.
- cfg_pulse_width  in  PW_WIDTH  ALERT_n low time in cycles; 0 is treated as 1.
- cfg_block_en  in  1  1 = hold the command block after the pulse until clr.
- clr  in  1  one-cycle clear of the sticky log and block state.
- alert_n  out  1  registered alert, active low; reset 1.
- cmd_block  out  1  inhibits downstream command forwarding; reset 0.
- err_sticky  out  1  an error has been logged since the last clr; reset 0.
- err_log_bus_id  out  8  lowest-index failing bus of the logged event; reset 0.
- err_log_vector  out  NUM_BUSES  err_vector of the logged event; reset 0.
- err_log_word  out  DWIDTH+1  failing word of the logged event; reset 0.
- err_count  out  CNT_WIDTH  count of accepted error events, saturating; reset 0.
- err_overflow  out  1  sticky; an error arrived while ALERT or BLOCK was busy; reset 0.
- state_o  out  2  FSM state encoding; reset IDLE.

## Operation
- An error event is a cycle with err_valid=1 and err_vector!=0.
  - err_valid=1 with err_vector=0 is ignored entirely: no count, no state change.
- Every error event increments err_count in every state. The count saturates at all-ones and is cleared only by rst.
- FSM states: IDLE=0, ALERT=1, BLOCK=2. Encoding 3 is illegal and recovers to IDLE.
- IDLE, on an error event:
  - Capture the log: bus_id = lowest i with err_vector[i]=1; word = bus_in[bus_id]; vector = err_vector.
  - Set err_sticky.
  - Load the pulse counter with max(cfg_pulse_width,1).
  - Go to ALERT.
- ALERT:
  - alert_n=0 and cmd_block=1.
  - The counter decrements each cycle. On the cycle it equals 1: go to BLOCK if cfg_block_en=1, else IDLE.
  - clr is ignored.
  - An error event is counted and sets err_overflow. It does not update the log and does not retrigger the pulse.
- BLOCK:
  - alert_n=1 and cmd_block=1.
  - clr goes to IDLE and clears err_sticky, the log and err_overflow.
  - An error event is counted and sets err_overflow. It does not update the log.
- clr in IDLE clears err_sticky, the log and err_overflow. err_count is unaffected.
- Simultaneous events:
  - IDLE with clr and an error event: the error wins. The new log is captured, err_sticky=1, err_overflow=0, go to ALERT.
  - BLOCK with clr and an error event: clr wins. Go to IDLE and clear everything except err_count, which still increments. The error is not logged.
- Reset mid-pulse: alert_n goes to 1 and cmd_block to 0 immediately (asynchronously). All state returns to reset values.

## Timing
- All outputs are registered.
- An error event in cycle T gives alert_n=0, cmd_block=1, err_sticky=1, the log, and err_count+1, all visible in T+1.
- alert_n is low for exactly max(cfg_pulse_width,1) consecutive cycles.
- cfg_pulse_width is sampled only on the IDLE->ALERT transition.
- cfg_block_en is sampled on the final ALERT cycle.
- Without block: cmd_block deasserts in the same cycle alert_n returns high.
- clr in BLOCK at cycle T: cmd_block=0 at T+1.
- Back-to-back: an error event in the first IDLE cycle after a pulse starts a new pulse at the next edge. There is no dead cycle requirement.

## Configuration
- PARITY_ALERT_LOG_EN defined: err_log_bus_id, err_log_vector and err_log_word are implemented as described.
- PARITY_ALERT_LOG_EN undefined: no log registers are built and those three outputs are tied to 0. err_sticky, err_count, err_overflow and the FSM are unchanged.

## Structure
- Package rcd_parity_pkg holds:
  - the alert FSM state enum (IDLE/ALERT/BLOCK);
  - default width constants (DWIDTH, PW_WIDTH, CNT_WIDTH);
  - a saturating-increment function.
- One sub-module, parity_alert_timer: loads the pulse counter, decrements it, and flags the last cycle. The FSM, log and counter stay in parity_alert_ctrl.

## Test plan
- Error on bus 2 (err_vector=4'b0100), cfg_pulse_width=4, cfg_block_en=0 -> alert_n low for exactly 4 cycles starting T+1; err_log_bus_id=2; err_count=1; cmd_block falls with alert_n.
- err_vector=4'b1010, cfg_pulse_width=0, cfg_block_en=1 -> 1-cycle alert, err_log_bus_id=1, then BLOCK with cmd_block=1 until clr; clr at T gives cmd_block=0 and err_sticky=0 at T+1.
- Three error events during ALERT -> err_count=4, err_overflow=1, log still holds the first event, pulse length unchanged.
- clr together with an error event in BLOCK -> IDLE, log cleared, err_count increments, no new pulse.
- err_count preset to 16'hFFFE and two errors -> err_count=16'hFFFF, held.
- rst asserted mid-ALERT -> alert_n=1, cmd_block=0, state_o=0 immediately, all outputs at reset values.
